// File: rtl/cfs_apb_pkg.sv
// Shared types and sizing helpers for the cfs APB completer and its storage.
package cfs_apb_pkg;

  // Widest data and address buses the completer is built for.
  localparam int CFS_APB_MAX_DATA_W = 32;
  localparam int CFS_APB_MAX_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } apb_state_e;

  typedef enum logic {
    RESP_OKAY   = 1'b0,
    RESP_SLVERR = 1'b1
  } apb_resp_e;

  // Derived sizes. Callers turn these into their own localparams, because a
  // package cannot see a module's parameters:
  //   STRB_W = DATA_WIDTH/8, IDX_W = $clog2(DEPTH), OFF_W = $clog2(STRB_W).
  function automatic int cfs_strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int cfs_idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cfs_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/cfs_apb_slave_regfile.sv
// Word storage for the APB completer: byte-enable write port, one combinational
// read port, every word cleared by the asynchronous reset.
module cfs_apb_slave_regfile
  import cfs_apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              we,
  input  logic [cfs_idx_w(DEPTH)-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic [cfs_strb_w(DATA_WIDTH)-1:0] wstrb,
  input  logic [cfs_idx_w(DEPTH)-1:0]       raddr,
  output logic [DATA_WIDTH-1:0]             rdata
);

  localparam int STRB_W = cfs_strb_w(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Next memory image: only the strobed byte lanes of the addressed word move.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_d[waddr][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  // Storage flops, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cfs_apb_slave_mem.sv
// APB4 completer backed by a byte-writable word memory, with programmable
// wait states, address-error response and protocol-abort detection.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | no transfer; a setup phase latches the request and wait count
//   ST_ACCESS | counting wait states; bus must hold psel & penable or it aborts
//   ST_DONE   | pready high; the transfer completes (write lands) on this edge
//
// A zero-wait transfer goes from ST_IDLE straight to ST_DONE. With registered
// outputs, that is the only way pready can be high in the cycle right after
// setup.
module cfs_apb_slave_mem
  import cfs_apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int WAIT_W     = 4
) (
  input  logic                              pclk,
  input  logic                              preset,
  input  logic                              psel,
  input  logic                              penable,
  input  logic                              pwrite,
  input  logic [ADDR_WIDTH-1:0]             paddr,
  input  logic [DATA_WIDTH-1:0]             pwdata,
  input  logic [cfs_strb_w(DATA_WIDTH)-1:0] pstrb,
  output logic                              pready,
  output logic [DATA_WIDTH-1:0]             prdata,
  output logic                              pslverr,
  input  logic [WAIT_W-1:0]                 wait_cfg,
  output logic                              proto_err
);

  localparam int STRB_W = cfs_strb_w(DATA_WIDTH);
  localparam int IDX_W  = cfs_idx_w(DEPTH);
  localparam int OFF_W  = cfs_off_w(DATA_WIDTH);

  apb_state_e            state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  proto_err_q, proto_err_d;

  logic [ADDR_WIDTH-1:0] dec_addr;
  logic                  cur_write;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic                  finish;
  apb_resp_e             resp;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  mem_we;

  // In IDLE the live bus is decoded so a zero-wait access can respond at once;
  // afterwards only the latched request is used.
  always_comb begin
    dec_addr  = (state_q == ST_IDLE) ? paddr  : addr_q;
    cur_write = (state_q == ST_IDLE) ? pwrite : write_q;
    dec_idx   = IDX_W'(dec_addr >> OFF_W);
    dec_err   = ((dec_addr & ADDR_WIDTH'(STRB_W - 1)) != '0) ||
                ((dec_addr >> (OFF_W + IDX_W)) != '0);
    resp      = dec_err ? RESP_SLVERR : RESP_OKAY;
    mem_we    = (state_q == ST_DONE) && write_q && !dec_err;
  end

  // Next-state, wait-counter and response logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = '0;
    proto_err_d = 1'b0;
    finish      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          cnt_d   = wait_cfg;
          if (wait_cfg == '0) begin
            finish = 1'b1;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (!(psel && penable)) begin
          proto_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end else if (cnt_q <= WAIT_W'(1)) begin
          // Terminal count: this edge raises pready for the last cycle.
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finish) begin
      state_d   = ST_DONE;
      cnt_d     = '0;
      pready_d  = 1'b1;
      pslverr_d = (resp == RESP_SLVERR);
      prdata_d  = (!cur_write && !dec_err) ? rd_data : '0;
    end
  end

  // FSM, latched request and registered outputs.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  cfs_apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regfile (
    .clk   (pclk),
    .rst   (preset),
    .we    (mem_we),
    .waddr (dec_idx),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .raddr (dec_idx),
    .rdata (rd_data)
  );

  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign prdata    = prdata_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cfs_apb_slave_mem.sv
// Bench for cfs_apb_slave_mem: directed scenarios plus random transfers,
// all compared against a word-array reference model.
module tb_cfs_apb_slave_mem;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int DEPTH = 16;

  logic        pclk;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [3:0]  wait_cfg;
  logic        proto_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [DEPTH];

  cfs_apb_slave_mem #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (16),
    .DEPTH      (DEPTH),
    .WAIT_W     (4)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr),
    .wait_cfg  (wait_cfg),
    .proto_err (proto_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic bus_idle(input int n);
    repeat (n) begin
      @(negedge pclk);
      psel    = 1'b0;
      penable = 1'b0;
    end
  endtask

  // One APB transfer. abort_k / rst_k (1-based access cycle, 0 = never) drop
  // psel or pulse reset in that cycle. The bus is left in its access phase on
  // normal completion so a following call runs back-to-back.
  task automatic apb_xfer(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w, input int abort_k,
                          input int rst_k, output logic [31:0] rd);
    int          a;
    int          idx;
    bit          exp_err;
    logic [31:0] exp_rd;
    a       = int'(addr);
    exp_err = (a % 4 != 0) || (a >= DEPTH * 4);
    idx     = (a / 4) % DEPTH;
    exp_rd  = (wr || exp_err) ? 32'h0 : model_mem[idx];
    rd      = 32'hBAD0_BAD0;

    @(negedge pclk);
    chk("idle_pready", {31'b0, pready}, 32'd0);
    chk("idle_prdata", prdata, 32'd0);
    chk("idle_proto", {31'b0, proto_err}, 32'd0);
    psel     = 1'b1;
    penable  = 1'b0;
    pwrite   = wr;
    paddr    = addr;
    pwdata   = data;
    pstrb    = strb;
    wait_cfg = 4'(w);

    for (int k = 1; k <= w + 1; k++) begin
      @(negedge pclk);
      if (k == 1) begin
        // Scramble everything but the handshake: the DUT must use the setup values.
        penable  = 1'b1;
        pwrite   = ~wr;
        paddr    = 16'($urandom);
        pwdata   = $urandom;
        pstrb    = 4'($urandom);
        wait_cfg = 4'($urandom);
      end
      if (k == w + 1) begin
        chk("done_pready", {31'b0, pready}, 32'd1);
        chk("done_pslverr", {31'b0, pslverr}, {31'b0, exp_err});
        chk("done_prdata", prdata, exp_rd);
        rd = prdata;
      end else begin
        chk("wait_pready", {31'b0, pready}, 32'd0);
      end
      if (k == rst_k) begin
        preset = 1'b1;
        #1;
        chk("rst_pready", {31'b0, pready}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
        model_clear();
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        preset = 1'b0;
        return;
      end
      if (k == abort_k) begin
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        chk("abort_proto", {31'b0, proto_err}, 32'd1);
        chk("abort_pready", {31'b0, pready}, 32'd0);
        @(negedge pclk);
        chk("abort_proto_end", {31'b0, proto_err}, 32'd0);
        chk("abort_pready_end", {31'b0, pready}, 32'd0);
        return;
      end
    end

    if (wr && !exp_err) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          wr;
    int          sel;
    int          w;
    int          ab;
    logic [15:0] a;

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; wait_cfg = '0;
    model_clear();
    repeat (3) @(negedge pclk);
    chk("reset_pready", {31'b0, pready}, 32'd0);
    chk("reset_prdata", prdata, 32'd0);
    chk("reset_pslverr", {31'b0, pslverr}, 32'd0);
    chk("reset_proto", {31'b0, proto_err}, 32'd0);
    preset = 1'b0;

    // Zero-wait read of a cleared word.
    apb_xfer(1'b0, 16'h0000, 32'h0, 4'h0, 0, 0, 0, rd);
    chk("plan_read0", rd, 32'h0000_0000);
    bus_idle(1);

    // Full-word write with three wait states, then read back.
    apb_xfer(1'b1, 16'h0004, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, rd);
    bus_idle(1);
    apb_xfer(1'b0, 16'h0004, 32'h0, 4'h0, 0, 0, 0, rd);
    chk("plan_deadbeef", rd, 32'hDEAD_BEEF);
    bus_idle(1);

    // Partial strobes.
    apb_xfer(1'b1, 16'h0004, 32'h1122_3344, 4'h5, 1, 0, 0, rd);
    bus_idle(1);
    apb_xfer(1'b0, 16'h0004, 32'h0, 4'h0, 2, 0, 0, rd);
    chk("plan_strb5", rd, 32'hDE22_BE44);
    bus_idle(1);

    // Out-of-range and misaligned accesses; an errored write must not alias word 0.
    apb_xfer(1'b0, 16'h0040, 32'h0, 4'h0, 0, 0, 0, rd);
    chk("plan_rd_oor", rd, 32'h0);
    apb_xfer(1'b0, 16'h0006, 32'h0, 4'h0, 1, 0, 0, rd);
    chk("plan_rd_mis", rd, 32'h0);
    apb_xfer(1'b1, 16'h0040, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, rd);
    apb_xfer(1'b0, 16'h0000, 32'h0, 4'h0, 0, 0, 0, rd);
    chk("plan_oor_nowrite", rd, 32'h0);
    apb_xfer(1'b0, 16'h0004, 32'h0, 4'h0, 0, 0, 0, rd);
    chk("plan_word1_kept", rd, 32'hDE22_BE44);
    bus_idle(1);

    // Abort in the second of five wait states leaves the old value.
    apb_xfer(1'b1, 16'h0008, 32'hCAFE_F00D, 4'hF, 0, 0, 0, rd);
    bus_idle(1);
    apb_xfer(1'b1, 16'h0008, 32'h0BAD_0BAD, 4'hF, 5, 2, 0, rd);
    apb_xfer(1'b0, 16'h0008, 32'h0, 4'h0, 0, 0, 0, rd);
    chk("plan_abort_kept", rd, 32'hCAFE_F00D);
    bus_idle(1);

    // Back-to-back write/read of word 0; reset hits during the read's pready cycle.
    apb_xfer(1'b1, 16'h0000, 32'hA5A5_5A5A, 4'hF, 1, 0, 0, rd);
    apb_xfer(1'b0, 16'h0000, 32'h0, 4'h0, 0, 0, 1, rd);
    chk("plan_b2b_rd", rd, 32'hA5A5_5A5A);
    apb_xfer(1'b0, 16'h0000, 32'h0, 4'h0, 0, 0, 0, rd);
    chk("plan_rst_clr0", rd, 32'h0);
    bus_idle(1);

    // Reset in the middle of a waited write.
    apb_xfer(1'b1, 16'h000C, 32'h1234_5678, 4'hF, 0, 0, 0, rd);
    bus_idle(1);
    apb_xfer(1'b1, 16'h000C, 32'hFFFF_FFFF, 4'hF, 3, 0, 2, rd);
    apb_xfer(1'b0, 16'h000C, 32'h0, 4'h0, 0, 0, 0, rd);
    chk("plan_rst_clr3", rd, 32'h0);
    bus_idle(1);

    // Random traffic against the model.
    for (int n = 0; n < 250; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      a = 16'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel < 9) a = 16'($urandom_range(0, DEPTH * 4 - 1));
      else              a = 16'($urandom_range(DEPTH * 4, 65535));
      w  = int'($urandom_range(0, 4));
      ab = 0;
      if (w > 0 && $urandom_range(0, 7) == 0) ab = int'($urandom_range(1, w));
      apb_xfer(wr, a, $urandom, 4'($urandom), w, ab, 0, rd);
      if ($urandom_range(0, 1) == 1) bus_idle(1);
    end

    // Final sweep of every word.
    bus_idle(1);
    for (int i = 0; i < DEPTH; i++) begin
      apb_xfer(1'b0, 16'(i * 4), 32'h0, 4'h0, 0, 0, 0, rd);
    end
    bus_idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
